// File: rtl/shift_rx_ctrl_pkg.sv
// Shared definitions for the serial receive controller: FSM encoding,
// default geometry and counter sizing.
package shift_rx_ctrl_pkg;

  localparam int N_DEFAULT   = 7;
  localparam int DIV_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // Width able to hold values 0..max_val-1, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/shift_rx_ctrl_if.sv
// Handshake and shift-register bus between the receive controller and its
// surroundings (data source, external shift register, consumer).
interface shift_rx_ctrl_if
  import shift_rx_ctrl_pkg::*;
#(
  parameter int N = N_DEFAULT
) ();

  logic         start;
  logic         abort;
  logic         ser_in;
  logic [N-1:0] sr_pr;
  logic         ready;
  logic         sr_enable;
  logic         sr_in;
  logic         sr_clear_n;
  logic [N-1:0] data_out;
  logic         valid;
  logic         busy;
  logic         overrun;

  modport slave (
    input  start, abort, ser_in, sr_pr, ready,
    output sr_enable, sr_in, sr_clear_n, data_out, valid, busy, overrun
  );

  modport master (
    output start, abort, ser_in, sr_pr, ready,
    input  sr_enable, sr_in, sr_clear_n, data_out, valid, busy, overrun
  );

endinterface

// File: rtl/shift_rx_ctrl_bit_tick.sv
// Bit-period divider: counts 0..DIV-1 while enabled and flags the last
// count of every bit window.
module bit_tick_gen
  import shift_rx_ctrl_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            TW       = cnt_width(DIV);
  localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);

  logic [TW-1:0] cnt;

  assign tick = en && (cnt == TICK_MAX);

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == TICK_MAX) ? '0 : cnt + TW'(1);
    end
  end

endmodule

// File: rtl/shift_rx_ctrl.sv
// Serial word receiver controller: paces an external right-shift register
// one bit per DIV clocks, captures the word and holds it for a consumer.
module shift_rx_ctrl
  import shift_rx_ctrl_pkg::*;
#(
  parameter int N   = N_DEFAULT,
  parameter int DIV = DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  shift_rx_ctrl_if.slave    bus
);

  localparam int            BW       = cnt_width(N + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

  state_t        state;
  state_t        state_nxt;
  logic [BW-1:0] bit_cnt;
  logic [N-1:0]  data_q;
  logic          overrun_q;
  logic          tick;
  logic          tick_clr;
  logic          tick_en;
  logic          shift_en;
  logic          capture_en;
  logic          clear_req;

  // Counters rest at zero whenever idle, so each start begins a fresh window.
  assign tick_clr = (state == IDLE);
  assign tick_en  = (state == SHIFT) && !bus.abort;

  bit_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .en   (tick_en),
    .tick (tick)
  );

  always_comb begin
    state_nxt  = state;
    shift_en   = 1'b0;
    capture_en = 1'b0;
    clear_req  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          clear_req = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          state_nxt = IDLE;
        end else if (tick) begin
          shift_en = 1'b1;
          if (bit_cnt == BIT_LAST) begin
            state_nxt = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (bus.abort) begin
          state_nxt = IDLE;
        end else begin
          capture_en = 1'b1;
          state_nxt  = HOLD;
        end
      end
      HOLD: begin
        if (bus.ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (shift_en && (bit_cnt != BW'(N))) begin
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (capture_en) begin
        data_q <= bus.sr_pr;
      end
      // A start seen outside IDLE is dropped, never queued; only flag it.
      if (bus.start && (state != IDLE)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // The external register is held clear for the whole reset period as well.
  assign bus.sr_clear_n = rst && !clear_req;
  assign bus.sr_enable  = shift_en;
  assign bus.sr_in      = bus.ser_in;
  assign bus.data_out   = data_q;
  assign bus.valid      = (state == HOLD);
  assign bus.busy       = (state != IDLE);
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_shift_rx_ctrl.sv
// Directed bench for shift_rx_ctrl with N=7, DIV=4 and a model of the
// external right-shift register.
module tb_shift_rx_ctrl;

  logic       clk;
  logic       rst;
  logic [6:0] sr;
  int         checks;
  int         errors;

  shift_rx_ctrl_if #(.N(7)) bus ();

  shift_rx_ctrl #(.N(7), .DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External right-shift register: new bit enters at the MSB.
  always_ff @(posedge clk) begin
    if (!bus.sr_clear_n) sr <= '0;
    else if (bus.sr_enable) sr <= {bus.sr_in, sr[6:1]};
  end
  assign bus.sr_pr = sr;

  typedef struct {
    logic       start;
    logic       abort;
    logic       ready;
    logic       ser;
    logic       en;
    logic       clr_n;
    logic       vld;
    logic       bsy;
    logic       ovr;
    logic [6:0] dout;
  } vec_t;

  vec_t tbl [0:45];
  int   ser_seq [0:6] = '{1, 0, 1, 1, 0, 0, 1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one cycle's inputs just after the edge, then park mid-cycle.
  task automatic step(input logic r, input logic s, input logic a,
                      input logic rd, input logic si);
    @(posedge clk);
    #1;
    rst        = r;
    bus.start  = s;
    bus.abort  = a;
    bus.ready  = rd;
    bus.ser_in = si;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses, last_pulse, cnt, lat;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.ready = 1'b0; bus.ser_in = 1'b0;

    for (int c = 0; c <= 45; c++) begin
      tbl[c].start = (c == 0);
      tbl[c].abort = (c == 35) || (c == 43);
      tbl[c].ready = ((c >= 10) && (c <= 12)) || (c == 40) || (c == 44);
      tbl[c].ser   = (c >= 1 && c <= 28) ? ser_seq[(c - 1) / 4][0] : 1'b0;
      tbl[c].en    = (c >= 4) && (c <= 28) && (c % 4 == 0);
      tbl[c].clr_n = (c != 0);
      tbl[c].vld   = (c >= 30) && (c <= 40);
      tbl[c].bsy   = (c >= 1) && (c <= 40);
      tbl[c].ovr   = 1'b0;
      tbl[c].dout  = (c >= 30) ? 7'h4D : 7'h00;
    end

    // Reset state
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_sr_enable", bus.sr_enable, 0);
    chk("rst_sr_clear_n", bus.sr_clear_n, 0);
    chk("rst_data_out", bus.data_out, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Basic word 7'h4D with delayed ready, plus ignored abort/ready
    for (int c = 0; c <= 45; c++) begin
      step(1, tbl[c].start, tbl[c].abort, tbl[c].ready, tbl[c].ser);
      chk($sformatf("t%0d_sr_enable", c), bus.sr_enable, tbl[c].en);
      chk($sformatf("t%0d_sr_clear_n", c), bus.sr_clear_n, tbl[c].clr_n);
      chk($sformatf("t%0d_valid", c), bus.valid, tbl[c].vld);
      chk($sformatf("t%0d_busy", c), bus.busy, tbl[c].bsy);
      chk($sformatf("t%0d_overrun", c), bus.overrun, tbl[c].ovr);
      chk($sformatf("t%0d_data_out", c), bus.data_out, tbl[c].dout);
    end

    // Abort after three pulses
    step(1, 1, 0, 0, 0);
    pulses = 0; last_pulse = -1;
    for (int c = 1; c <= 13; c++) begin
      step(1, 0, (c == 13), 0, 0);
      if (bus.sr_enable) begin
        pulses++;
        last_pulse = c;
      end
    end
    chk("abort_pulses", pulses, 3);
    chk("abort_last_pulse", last_pulse, 12);
    step(1, 0, 0, 0, 0);
    chk("abort_idle_busy", bus.busy, 0);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      step(1, 0, 0, 0, 0);
      if (bus.valid || bus.sr_enable) cnt++;
    end
    chk("abort_no_valid", cnt, 0);

    // Fresh word of all ones after abort
    step(1, 1, 0, 0, 1);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      step(1, 0, 0, 0, 1);
      lat = c;
      if (bus.valid) break;
    end
    chk("ones_latency", lat, 30);
    chk("ones_data", bus.data_out, 7'h7F);
    chk("ones_overrun", bus.overrun, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    chk("ones_valid_drop", bus.valid, 0);
    chk("ones_busy_drop", bus.busy, 0);

    // Start during SHIFT: overrun, word completes, no queued second word
    step(1, 1, 0, 0, 0);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      step(1, (c == 10), 0, 0, ((c - 1) / 4) % 2 == 1);
      lat = c;
      if (c == 11) chk("ovr_set", bus.overrun, 1);
      if (bus.valid) break;
    end
    chk("ovr_latency", lat, 30);
    chk("ovr_data", bus.data_out, 7'h2A);
    step(1, 0, 0, 1, 0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      step(1, 0, 0, 0, 0);
      if (bus.busy) cnt++;
    end
    chk("ovr_not_queued", cnt, 0);
    chk("ovr_sticky", bus.overrun, 1);

    // Reset mid-word
    step(1, 1, 0, 0, 1);
    for (int c = 1; c <= 19; c++) step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_valid", bus.valid, 0);
    chk("mrst_overrun", bus.overrun, 0);
    chk("mrst_sr_enable", bus.sr_enable, 0);
    chk("mrst_sr_clear_n", bus.sr_clear_n, 0);
    chk("mrst_data_out", bus.data_out, 0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      step(1, 0, 0, 0, 1);
      if (bus.valid || bus.busy) cnt++;
    end
    chk("mrst_no_word", cnt, 0);

    // Start coinciding with the HOLD handshake
    step(1, 1, 0, 0, 0);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      step(1, 0, 0, 0, (c % 2) == 1);
      lat = c;
      if (bus.valid) break;
    end
    chk("hs_latency", lat, 30);
    chk("hs_overrun_before", bus.overrun, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    chk("hs_busy", bus.busy, 0);
    chk("hs_valid", bus.valid, 0);
    chk("hs_overrun", bus.overrun, 1);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      step(1, 0, 0, 0, 0);
      if (bus.busy) cnt++;
    end
    chk("hs_start_ignored", cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
